ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 148 ++++++++++++++
 tb/tb_ifu_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/gnt/rvalid bus and buffers {inst, addr} for decode.
// Optional IFU_MISALIGN_CHECK_EN adds fetch_misalign_o and parks fetch on a misaligned jump target.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ifu_fetch #(
  parameter logic [31:0]            RESET_PC   = 32'h0000_0000,
  parameter int unsigned            FIFO_DEPTH = 2,
  parameter logic [`DATA_WIDTH-1:0] NOP_INST   = `DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_i,
  input  logic [31:0]            jump_addr_i,
  output logic                   ibus_req_o,
  output logic [31:0]            ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [`DATA_WIDTH-1:0] ibus_rdata_i,
  output logic [`DATA_WIDTH-1:0] inst_o,
  output logic [31:0]            inst_addr_o,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic                   fetch_misalign_o,
`endif
  output logic                   inst_valid_o
);

  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_drop;
  logic          r_mis;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [DW-1:0] r_mem_inst [FIFO_DEPTH];
  logic [31:0]   r_mem_addr [FIFO_DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_jump_mis;
  logic [31:0]   w_jump_pc;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_jump_mis       = (jump_addr_i[1:0] != 2'b00);
  assign w_jump_pc        = jump_addr_i;
  assign fetch_misalign_o = r_mis;
`else
  assign w_jump_mis       = 1'b0;
  assign w_jump_pc        = jump_addr_i & ~32'h0000_0003;
`endif

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_C);
  assign ibus_req_o   = (r_state == S_REQ) && !w_full && !r_mis;
  assign ibus_addr_o  = r_pc;
  assign w_gnt        = ibus_req_o && ibus_gnt_i;
  assign w_push       = (r_state == S_WAIT) && ibus_rvalid_i && !r_drop && !jump_i;
  assign inst_valid_o = !w_empty && !jump_i;
  assign w_pop        = inst_valid_o && !stall_i;
  assign inst_o       = w_empty ? NOP_INST : r_mem_inst[r_rd_ptr];
  assign inst_addr_o  = w_empty ? 32'h0 : r_mem_addr[r_rd_ptr];

  // Buffer storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= ibus_rdata_i;
      r_mem_addr[r_wr_ptr] <= r_req_pc;
    end
  end

  // FSM, PC and FIFO bookkeeping; a jump overrides push, pop and stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'h0;
      r_drop   <= 1'b0;
      r_mis    <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (jump_i) begin
      r_pc     <= w_jump_pc;
      r_mis    <= w_jump_mis;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_gnt) begin
            r_req_pc <= r_pc;
            r_drop   <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_gnt) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: cycle table with hand-computed outputs plus bus-responder sequences.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i, jump_i, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] jump_addr_i, ibus_rdata_i;
  logic        ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_o, inst_addr_o;
  logic        fetch_misalign_o;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
`ifdef IFU_MISALIGN_CHECK_EN
    .fetch_misalign_o (fetch_misalign_o),
`endif
    .inst_valid_o  (inst_valid_o)
  );

`ifndef IFU_MISALIGN_CHECK_EN
  assign fetch_misalign_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        st, jp, gn, rv;
    logic [31:0] jaddr, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst, e_iaddr;
    logic        e_mis;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  // Bus responder state for the hand-written sequences.
  logic        pend, holding;
  logic [31:0] pend_addr, hold_addr, exp_pop;
  int          hold_cnt, hold_need, nrv, n8, pops;

  function automatic vec_t mk(input logic st, jp, gn, rv, input logic [31:0] jaddr, rdata,
                              input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_inst, e_iaddr, input logic e_mis);
    vec_t v;
    v.st = st; v.jp = jp; v.gn = gn; v.rv = rv; v.jaddr = jaddr; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_inst = e_inst; v.e_iaddr = e_iaddr; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stall_i = 0; jump_i = 0; jump_addr_i = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 0;
    pend = 0; holding = 0; hold_cnt = 0; hold_need = 0; pend_addr = 0; hold_addr = 0;
    nrv = 0; n8 = 0; pops = 0; exp_pop = 0;
    #1;
    chk("rst req", 32'(ibus_req_o), 32'd0);
    chk("rst valid", 32'(inst_valid_o), 32'd0);
    chk("rst inst", inst_o, NOP);
    chk("rst iaddr", inst_addr_o, 32'h0);
    chk("rst pc", ibus_addr_o, 32'h0);
    chk("rst mis", 32'(fetch_misalign_o), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One cycle of a 1-cycle-latency slave with optional grant hold-off on hold_addr.
  task automatic bus_drive(input logic st);
    @(negedge clk);
    stall_i = st; jump_i = 0; jump_addr_i = 0;
    ibus_rvalid_i = pend;
    ibus_rdata_i  = pat(pend_addr);
    if (pend) begin
      nrv++;
      if (pend_addr == 32'h8) n8++;
    end
    pend = 0;
    #1;
    if (holding) begin
      chk("hold req", 32'(ibus_req_o), 32'd1);
      chk("hold addr", ibus_addr_o, hold_addr);
    end
    ibus_gnt_i = 0;
    holding = 0;
    if (ibus_req_o) begin
      if (ibus_addr_o == hold_addr && hold_cnt < hold_need) begin
        hold_cnt++;
        holding = 1;
      end else begin
        ibus_gnt_i = 1;
        pend = 1;
        pend_addr = ibus_addr_o;
      end
    end
    if (inst_valid_o && !st) begin
      chk($sformatf("pop%0d addr", pops), inst_addr_o, exp_pop);
      chk($sformatf("pop%0d inst", pops), inst_o, pat(exp_pop));
      exp_pop += 32'd4;
      pops++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //            st jp gn rv jaddr          rdata          req     addr                       val inst           iaddr          mis
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b0,   32'h0,                     0, NOP,           32'h0,         0);
    tbl[1]  = mk(0, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h0,                     0, NOP,           32'h0,         0);
    tbl[2]  = mk(0, 0, 0, 1, 32'h0,         32'h00500093,  1'b0,   32'h4,                     0, NOP,           32'h0,         0);
    tbl[3]  = mk(1, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h4,                     1, 32'h00500093,  32'h0,         0);
    tbl[4]  = mk(1, 0, 0, 1, 32'h0,         32'h00100113,  1'b0,   32'h8,                     1, 32'h00500093,  32'h0,         0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b0,   32'h8,                     1, 32'h00500093,  32'h0,         0);
    tbl[6]  = mk(1, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h8,                     1, 32'h00100113,  32'h4,         0);
    tbl[7]  = mk(0, 1, 0, 0, 32'h100,       32'h0,         1'b0,   32'hC,                     0, 32'h00100113,  32'h4,         0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h0,         32'hDEADBEEF,  1'b0,   32'h100,                   0, NOP,           32'h0,         0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h100,                   0, NOP,           32'h0,         0);
    tbl[10] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h100,                   0, NOP,           32'h0,         0);
    tbl[11] = mk(0, 0, 0, 1, 32'h0,         32'h00200193,  1'b0,   32'h104,                   0, NOP,           32'h0,         0);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h104,                   1, 32'h00200193,  32'h100,       0);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h104,                   0, NOP,           32'h0,         0);
    tbl[14] = mk(1, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h104,                   0, NOP,           32'h0,         0);
    tbl[15] = mk(1, 0, 0, 1, 32'h0,         32'h11111111,  1'b0,   32'h108,                   0, NOP,           32'h0,         0);
    tbl[16] = mk(1, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h108,                   1, 32'h11111111,  32'h104,       0);
    tbl[17] = mk(1, 1, 0, 1, 32'h200,       32'h22222222,  1'b0,   32'h10C,                   0, 32'h11111111,  32'h104,       0);
    tbl[18] = mk(1, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h200,                   0, NOP,           32'h0,         0);
    tbl[19] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'h200,                   0, NOP,           32'h0,         0);
    tbl[20] = mk(0, 0, 0, 1, 32'h0,         32'h33333333,  1'b0,   32'h204,                   0, NOP,           32'h0,         0);
    tbl[21] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h204,                   1, 32'h33333333,  32'h200,       0);
    tbl[22] = mk(0, 1, 0, 0, 32'h302,       32'h0,         1'b1,   32'h204,                   0, NOP,           32'h0,         0);
    tbl[23] = mk(0, 0, 0, 0, 32'h0,         32'h0,         !MIS,   MIS ? 32'h302 : 32'h300,   0, NOP,           32'h0,         MIS);
    tbl[24] = mk(0, 1, 0, 0, 32'h200,       32'h0,         !MIS,   MIS ? 32'h302 : 32'h300,   0, NOP,           32'h0,         MIS);
    tbl[25] = mk(0, 1, 0, 0, 32'hFFFFFFFC,  32'h0,         1'b1,   32'h200,                   0, NOP,           32'h0,         0);
    tbl[26] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1'b1,   32'hFFFFFFFC,              0, NOP,           32'h0,         0);
    tbl[27] = mk(0, 0, 0, 1, 32'h0,         32'h44444444,  1'b0,   32'h0,                     0, NOP,           32'h0,         0);
    tbl[28] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h0,                     1, 32'h44444444,  32'hFFFFFFFC,  0);
    tbl[29] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1'b1,   32'h0,                     0, NOP,           32'h0,         0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stall_i = tbl[i].st; jump_i = tbl[i].jp; jump_addr_i = tbl[i].jaddr;
      ibus_gnt_i = tbl[i].gn; ibus_rvalid_i = tbl[i].rv; ibus_rdata_i = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d req", i), 32'(ibus_req_o), 32'(tbl[i].e_req));
      chk($sformatf("v%0d addr", i), ibus_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d valid", i), 32'(inst_valid_o), 32'(tbl[i].e_val));
      chk($sformatf("v%0d inst", i), inst_o, tbl[i].e_inst);
      chk($sformatf("v%0d iaddr", i), inst_addr_o, tbl[i].e_iaddr);
`ifdef IFU_MISALIGN_CHECK_EN
      chk($sformatf("v%0d mis", i), 32'(fetch_misalign_o), 32'(tbl[i].e_mis));
`endif
    end

    // Stall from reset: two entries fill the buffer, then requests stop.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus_drive(1'b1);
      if (i >= 6) begin
        chk($sformatf("stall%0d req", i), 32'(ibus_req_o), 32'd0);
        chk($sformatf("stall%0d iaddr", i), inst_addr_o, 32'h0);
      end
    end
    chk("stall pushes", 32'(nrv), 32'd2);
    chk("stall valid", 32'(inst_valid_o), 32'd1);
    for (int i = 0; i < 20 && pops < 3; i++) bus_drive(1'b0);
    chk("stall drain pops", 32'(pops >= 3), 32'd1);

    // Grant withheld for three cycles on address 0x8.
    do_reset();
    hold_addr = 32'h8;
    hold_need = 3;
    repeat (16) bus_drive(1'b0);
    chk("gnt delay holds", 32'(hold_cnt), 32'd3);
    chk("gnt delay pushes of 0x8", 32'(n8), 32'd1);
    chk("gnt delay pops", 32'(pops >= 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
